// File: rtl/lsu_mem_if.sv
// Load/store unit: turns execute-stage LB/LH/LW/LBU/LHU/SB/SH/SW into word-aligned memory
// requests and returns one extended response per op. Optional: LSU_MISALIGN_TRAP_EN.
module lsu_mem_if #(
  parameter int unsigned WORD_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_store,
  input  logic [1:0]           req_size,
  input  logic                 req_unsigned,
  input  logic [WORD_SIZE-1:0] req_addr,
  input  logic [WORD_SIZE-1:0] req_wdata,
  input  logic [4:0]           req_rd,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [3:0]           mem_be,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic                 mem_gnt,
  input  logic                 mem_rvalid,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  output logic                 rsp_valid,
  output logic [4:0]           rsp_rd,
  output logic [WORD_SIZE-1:0] rsp_data
`ifdef LSU_MISALIGN_TRAP_EN
  ,
  output logic                 rsp_misaligned
`endif
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

  state_e state_q, state_d;

  logic                 store_q;
  logic [1:0]           size_q;
  logic                 unsigned_q;
  logic [1:0]           off_q;
  logic [4:0]           rd_q;
  logic                 we_q;
  logic [3:0]           be_q;
  logic [WORD_SIZE-1:0] addr_q;
  logic [WORD_SIZE-1:0] wdata_q;
  logic [4:0]           rsp_rd_q;
  logic [WORD_SIZE-1:0] rsp_data_q;
`ifdef LSU_MISALIGN_TRAP_EN
  logic                 misaligned_q;
`endif

  logic                 accept;
  logic                 fault;
  logic [1:0]           off_d;
  logic [3:0]           be_d;
  logic [WORD_SIZE-1:0] wdata_d;
  logic [WORD_SIZE-1:0] rdata_sh;
  logic [WORD_SIZE-1:0] load_ext;

  assign accept = (state_q == StIdle) && req_valid;

  // Request decode; size 3 falls through to word. Alignment is forced here, the trap build
  // additionally flags the original address as a fault.
  always_comb begin
    off_d   = 2'b00;
    be_d    = 4'b1111;
    wdata_d = req_wdata;
    case (req_size)
      2'd0: begin
        off_d   = req_addr[1:0];
        be_d    = 4'b0001 << off_d;
        wdata_d = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        off_d   = {req_addr[1], 1'b0};
        be_d    = 4'b0011 << off_d;
        wdata_d = {2{req_wdata[15:0]}};
      end
      default: begin
        off_d   = 2'b00;
        be_d    = 4'b1111;
        wdata_d = req_wdata;
      end
    endcase
`ifdef LSU_MISALIGN_TRAP_EN
    fault = ((req_size == 2'd1) && req_addr[0]) || (req_size[1] && (req_addr[1:0] != 2'b00));
`else
    fault = 1'b0;
`endif
  end

  always_comb begin
    rdata_sh = mem_rdata >> {off_q, 3'b000};
    case (size_q)
      2'd0:    load_ext = unsigned_q ? {{(WORD_SIZE-8){1'b0}}, rdata_sh[7:0]}
                                     : {{(WORD_SIZE-8){rdata_sh[7]}}, rdata_sh[7:0]};
      2'd1:    load_ext = unsigned_q ? {{(WORD_SIZE-16){1'b0}}, rdata_sh[15:0]}
                                     : {{(WORD_SIZE-16){rdata_sh[15]}}, rdata_sh[15:0]};
      default: load_ext = rdata_sh;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (req_valid) state_d = fault ? StResp : StReq;
      StReq:   if (mem_gnt) state_d = store_q ? StResp : StWait;
      StWait:  if (mem_rvalid) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready = (state_q == StIdle);
    mem_req   = (state_q == StReq);
    rsp_valid = (state_q == StResp);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      store_q      <= 1'b0;
      size_q       <= 2'd0;
      unsigned_q   <= 1'b0;
      off_q        <= 2'd0;
      rd_q         <= 5'd0;
      we_q         <= 1'b0;
      be_q         <= 4'd0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rsp_rd_q     <= 5'd0;
      rsp_data_q   <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      misaligned_q <= 1'b0;
`endif
    end else begin
      if (accept) begin
        store_q      <= req_store;
        size_q       <= req_size;
        unsigned_q   <= req_unsigned;
        off_q        <= off_d;
        rd_q         <= req_rd;
        we_q         <= req_store;
        be_q         <= be_d;
        addr_q       <= {req_addr[WORD_SIZE-1:2], 2'b00};
        wdata_q      <= wdata_d;
        rsp_rd_q     <= 5'd0;
        rsp_data_q   <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
        misaligned_q <= fault;
`endif
      end
      if ((state_q == StWait) && mem_rvalid) begin
        rsp_rd_q   <= rd_q;
        rsp_data_q <= load_ext;
      end
      // Response fields only carry meaning during the rsp_valid pulse.
      if (state_q == StResp) begin
        rsp_rd_q     <= 5'd0;
        rsp_data_q   <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
        misaligned_q <= 1'b0;
`endif
      end
    end
  end

  assign mem_we    = we_q;
  assign mem_be    = be_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rsp_rd    = rsp_rd_q;
  assign rsp_data  = rsp_data_q;
`ifdef LSU_MISALIGN_TRAP_EN
  assign rsp_misaligned = misaligned_q;
`endif

endmodule
